// File: rtl/led_pkg.sv
// Shared constants for the LED output blocks.
package led_pkg;

    localparam int LED_HOLD_DEFAULT = 5_000_000;
    localparam int LED_PWM_BITS     = 4;
    localparam int CLK_HZ           = 100_000_000;

endpackage

// File: rtl/led_pulse_stretch_if.sv
// Signal bundle between event-producing logic and the LED pulse stretcher.
interface led_pulse_stretch_if
    import led_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int PWM_BITS = LED_PWM_BITS
);

    // No valid/ready here: pulse is sampled on every clk edge, bright is a
    // level sampled every cycle, and busy/led are registered levels.
    logic [CHANNELS-1:0] pulse;
    logic [PWM_BITS-1:0] bright;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] led;

    modport master (output pulse, output bright, input busy, input led);
    modport slave  (input pulse, input bright, output busy, output led);

endinterface

// File: rtl/stretch_ch.sv
// One stretcher channel: hold down-counter, trigger acceptance and busy register.
module stretch_ch
    import led_pkg::*;
#(
    parameter int HOLD_CYCLES = LED_HOLD_DEFAULT,
    parameter int RETRIGGER   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic busy,
    output logic busy_next
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // A load wins over the decrement, even when the count is about to expire.
    always_comb begin
        cnt_next = cnt;
        if (pulse && ((cnt == '0) || (RETRIGGER != 0))) begin
            cnt_next = HOLD_VAL;
        end else if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end
    end

    assign busy_next = (cnt_next != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// Multi-channel pulse stretcher with shared PWM dimming of the LED outputs.
module led_pulse_stretch
    import led_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int HOLD_CYCLES = LED_HOLD_DEFAULT,
    parameter int PWM_BITS    = LED_PWM_BITS,
    parameter int RETRIGGER   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pulse_stretch_if.slave   bus
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] busy_next;
    logic [CHANNELS-1:0] led_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        stretch_ch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pulse     (bus.pulse[i]),
            .busy      (busy_q[i]),
            .busy_next (busy_next[i])
        );
    end

    // Full-scale brightness is forced on so the top code gives 100% duty.
    always_comb begin
        pwm_on = (bus.bright == PWM_MAX) || (pwm_cnt < bus.bright);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_q   <= busy_next & {CHANNELS{pwm_on}};
        end
    end

    assign bus.busy = busy_q;
    assign bus.led  = led_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch: three configurations checked through one expected queue.
module tb_led_pulse_stretch;

    logic clk;
    logic rst;

    int n_checks;
    int n_err;
    int edge_n;

    logic [47:0] exp_q[$];
    string       tag_q[$];

    led_pulse_stretch_if #(.CHANNELS(8), .PWM_BITS(2)) if_a ();
    led_pulse_stretch_if #(.CHANNELS(8), .PWM_BITS(2)) if_b ();
    led_pulse_stretch_if #(.CHANNELS(8), .PWM_BITS(2)) if_c ();

    led_pulse_stretch #(.CHANNELS(8), .HOLD_CYCLES(4), .PWM_BITS(2), .RETRIGGER(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    led_pulse_stretch #(.CHANNELS(8), .HOLD_CYCLES(4), .PWM_BITS(2), .RETRIGGER(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );
    led_pulse_stretch #(.CHANNELS(8), .HOLD_CYCLES(16), .PWM_BITS(2), .RETRIGGER(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic pwm_on(input logic [1:0] b, input logic [1:0] ph);
        return (b == 2'd3) || (ph < b);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: inputs are already set; queue expected outputs after the next edge
    task automatic step(input string tag, input logic [7:0] eb_a,
                        input logic [7:0] eb_b, input logic [7:0] eb_c);
        logic [1:0] ph;
        ph = 2'(edge_n);
        exp_q.push_back({eb_a, eb_a & {8{pwm_on(if_a.bright, ph)}},
                         eb_b, eb_b & {8{pwm_on(if_b.bright, ph)}},
                         eb_c, eb_c & {8{pwm_on(if_c.bright, ph)}}});
        tag_q.push_back(tag);
        @(posedge clk);
        if (rst) edge_n = 0;
        else     edge_n = edge_n + 1;
        @(negedge clk);
    endtask

    // monitor / scoreboard
    initial begin
        logic [47:0] e;
        string       t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, " busy_a"}, if_a.busy, e[47:40]);
                check({t, " led_a"},  if_a.led,  e[39:32]);
                check({t, " busy_b"}, if_b.busy, e[31:24]);
                check({t, " led_b"},  if_b.led,  e[23:16]);
                check({t, " busy_c"}, if_c.busy, e[15:8]);
                check({t, " led_c"},  if_c.led,  e[7:0]);
            end
        end
    end

    // stimulus
    initial begin
        n_checks = 0;
        n_err    = 0;
        edge_n   = 0;
        rst = 1'b1;
        if_a.pulse = '0; if_b.pulse = '0; if_c.pulse = '0;
        if_a.bright = 2'd3; if_b.bright = 2'd3; if_c.bright = 2'd1;

        #1;
        check("reset busy_a", if_a.busy, 8'h00);
        check("reset led_a",  if_a.led,  8'h00);
        check("reset busy_c", if_c.busy, 8'h00);
        @(negedge clk);
        step("reset", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        step("idle", 8'h00, 8'h00, 8'h00);

        // single trigger
        if_a.pulse = 8'h01;
        step("single", 8'h01, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        repeat (3) step("single", 8'h01, 8'h00, 8'h00);
        step("single_end", 8'h00, 8'h00, 8'h00);

        // retrigger at cycles 0 and 2: a=retrigger, b=ignore
        if_a.pulse = 8'h02; if_b.pulse = 8'h02;
        step("retrig", 8'h02, 8'h02, 8'h00);
        if_a.pulse = 8'h00; if_b.pulse = 8'h00;
        step("retrig", 8'h02, 8'h02, 8'h00);
        if_a.pulse = 8'h02; if_b.pulse = 8'h02;
        step("retrig", 8'h02, 8'h02, 8'h00);
        if_a.pulse = 8'h00; if_b.pulse = 8'h00;
        step("retrig", 8'h02, 8'h02, 8'h00);
        step("retrig", 8'h02, 8'h00, 8'h00);
        step("retrig", 8'h02, 8'h00, 8'h00);
        step("retrig_end", 8'h00, 8'h00, 8'h00);

        // pulse while cnt == 1
        if_a.pulse = 8'h04; if_b.pulse = 8'h04;
        step("cnt1", 8'h04, 8'h04, 8'h00);
        if_a.pulse = 8'h00; if_b.pulse = 8'h00;
        repeat (3) step("cnt1", 8'h04, 8'h04, 8'h00);
        if_a.pulse = 8'h04; if_b.pulse = 8'h04;
        step("cnt1_edge", 8'h04, 8'h00, 8'h00);
        if_a.pulse = 8'h00; if_b.pulse = 8'h00;
        repeat (3) step("cnt1", 8'h04, 8'h00, 8'h00);
        step("cnt1_end", 8'h00, 8'h00, 8'h00);

        // PWM at bright=1, then bright=0
        for (int i = 0; i < 16; i++) begin
            if_c.pulse = (i == 0) ? 8'h01 : 8'h00;
            step("pwm1", 8'h00, 8'h00, 8'h01);
        end
        if_c.pulse = 8'h00;
        step("pwm1_end", 8'h00, 8'h00, 8'h00);
        if_c.bright = 2'd0;
        for (int i = 0; i < 16; i++) begin
            if_c.pulse = (i == 0) ? 8'h01 : 8'h00;
            step("pwm0", 8'h00, 8'h00, 8'h01);
        end
        if_c.pulse = 8'h00;
        step("pwm0_end", 8'h00, 8'h00, 8'h00);

        // independence
        if_a.pulse = 8'hFF;
        step("indep", 8'hFF, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        step("indep", 8'hFF, 8'h00, 8'h00);
        if_a.pulse = 8'h08;
        step("indep", 8'hFF, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        step("indep", 8'hFF, 8'h00, 8'h00);
        step("indep", 8'h08, 8'h00, 8'h00);
        step("indep", 8'h08, 8'h00, 8'h00);
        step("indep_end", 8'h00, 8'h00, 8'h00);

        // reset mid-hold with pulse high during reset
        if_a.pulse = 8'h01;
        step("mid", 8'h01, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        step("mid", 8'h01, 8'h00, 8'h00);
        rst = 1'b1;
        if_a.pulse = 8'hFF;
        edge_n = 0;
        #1;
        check("async busy_a", if_a.busy, 8'h00);
        check("async led_a",  if_a.led,  8'h00);
        step("in_rst", 8'h00, 8'h00, 8'h00);
        step("in_rst", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        if_a.pulse = 8'h00;
        repeat (2) step("post_rst", 8'h00, 8'h00, 8'h00);
        if_a.pulse = 8'h01;
        step("post_rst", 8'h01, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        repeat (3) step("post_rst", 8'h01, 8'h00, 8'h00);
        step("post_rst_end", 8'h00, 8'h00, 8'h00);

        // level input at bright=2
        if_a.bright = 2'd2;
        if_a.pulse = 8'h20;
        repeat (10) step("level", 8'h20, 8'h00, 8'h00);
        if_a.pulse = 8'h00;
        repeat (3) step("level", 8'h20, 8'h00, 8'h00);
        step("level_end", 8'h00, 8'h00, 8'h00);
        step("final", 8'h00, 8'h00, 8'h00);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
